// File: rtl/it_seq_ctrl_pkg.sv
// Shared definitions for the Thumb IT-block sequencer: condition codes, APSR bit
// positions, IT opcode and ITSTATE field helpers.
package it_seq_ctrl_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int APSR_N = 4;
    localparam int APSR_Z = 3;
    localparam int APSR_C = 2;
    localparam int APSR_V = 1;
    localparam int APSR_Q = 0;

    localparam logic [7:0] IT_OPCODE = 8'hBF;

    // ITSTATE layout: [7:4] condition of the current instruction, [3:0] remaining mask.
    localparam int ITS_COND_LSB = 4;
    localparam int ITS_MASK_MSB = 3;

    // An all-zero mask encodes the NOP/YIELD hint family, not an IT.
    function automatic logic is_it_inst(input logic [15:0] hw);
        return (hw[15:8] == IT_OPCODE) && (hw[3:0] != 4'h0);
    endfunction

    function automatic logic it_fields_bad(input logic [7:0] fields);
        return (fields[7:4] == COND_NV) ||
               ((fields[7:4] == COND_AL) && (fields[3:0] != 4'b1000));
    endfunction

endpackage

// File: rtl/it_cond_eval.sv
// Combinational ARM condition-code check against the APSR flags; shared with the
// branch unit.
module it_cond_eval
    import it_seq_ctrl_pkg::*;
#(
    parameter int APSR_W = 5
) (
    input  logic [3:0]        i_cond,
    input  logic [APSR_W-1:0] i_apsr,
    output logic              o_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_unused_q;

    assign w_n        = i_apsr[APSR_N];
    assign w_z        = i_apsr[APSR_Z];
    assign w_c        = i_apsr[APSR_C];
    assign w_v        = i_apsr[APSR_V];
    assign w_unused_q = i_apsr[APSR_Q];

    // NOTE: every path assigns o_pass (default arm included), so no latch is inferred.
    always_comb begin
        case (cond_e'(i_cond))
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = w_z || (w_n != w_v);
            default: o_pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/it_seq_ctrl.sv
// Thumb IT-block sequencer: decodes IT, owns ITSTATE, demotes failing instructions
// to NOPs and counts them. IDLE/ACTIVE is derived from the ITSTATE mask.
module it_seq_ctrl
    import it_seq_ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int APSR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inst_valid,
    input  logic              i_stall,
    input  logic [15:0]       i_inst_hw,
    input  logic [APSR_W-1:0] i_apsr,
    input  logic              i_flush,
    input  logic              i_itstate_wr,
    input  logic [7:0]        i_itstate_wdata,
    output logic [7:0]        o_itstate,
    output logic              o_in_it_blk,
    output logic [3:0]        o_cur_cond,
    output logic              o_hint_or_exc,
    output logic              o_it_last,
    output logic              o_it_illegal,
    output logic [CNT_W-1:0]  o_skip_cnt
);

    logic [7:0]       r_itstate;
    logic             r_it_illegal;
    logic [CNT_W-1:0] r_skip_cnt;

    logic             w_in_blk;
    logic [3:0]       w_cur_cond;
    logic             w_pass;
    logic             w_hint;
    logic             w_is_it;
    logic             w_illegal;
    logic [7:0]       w_itstate_adv;

    assign w_in_blk   = (r_itstate[ITS_MASK_MSB:0] != 4'h0);
    assign w_cur_cond = w_in_blk ? r_itstate[7:ITS_COND_LSB] : COND_AL;

    it_cond_eval #(
        .APSR_W (APSR_W)
    ) u_cond_eval (
        .i_cond (w_cur_cond),
        .i_apsr (i_apsr),
        .o_pass (w_pass)
    );

    assign w_hint    = w_in_blk && !w_pass && (w_cur_cond[3:1] != 3'b111);
    assign w_is_it   = is_it_inst(i_inst_hw);
    assign w_illegal = w_is_it && (w_in_blk || it_fields_bad(i_inst_hw[7:0]));

    // The last instruction of a block empties the mask; otherwise shift cond[0]+mask, keep cond[3:1].
    assign w_itstate_adv = (r_itstate[2:0] == 3'b000) ? 8'h00
                         : {r_itstate[7:5], r_itstate[3:0], 1'b0};

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_itstate    <= 8'h00;
            r_it_illegal <= 1'b0;
            r_skip_cnt   <= '0;
        end else if (!i_stall) begin
            r_it_illegal <= 1'b0;
            if (i_flush) begin
                r_itstate <= 8'h00;
            end else if (i_itstate_wr) begin
                r_itstate <= i_itstate_wdata;
            end else if (i_inst_valid) begin
                if (w_in_blk) begin
                    r_itstate <= w_itstate_adv;
                end else if (w_is_it && !w_illegal) begin
                    r_itstate <= i_inst_hw[7:0];
                end
                r_it_illegal <= w_illegal;
            end
            if (i_inst_valid && w_hint && (r_skip_cnt != '1)) begin
                r_skip_cnt <= r_skip_cnt + CNT_W'(1);
            end
        end
    end

    assign o_itstate     = r_itstate;
    assign o_in_it_blk   = w_in_blk;
    assign o_cur_cond    = w_cur_cond;
    assign o_hint_or_exc = w_hint;
    assign o_it_last     = w_in_blk && (r_itstate[2:0] == 3'b000);
    assign o_it_illegal  = r_it_illegal;
    assign o_skip_cnt    = r_skip_cnt;

endmodule

// File: tb/tb_it_seq_ctrl.sv
// Directed bench for it_seq_ctrl; a narrow skip counter makes saturation reachable.
module tb_it_seq_ctrl;

    localparam int CNT_W  = 3;
    localparam int APSR_W = 5;

    localparam logic [4:0]  F_NONE = 5'b00000;
    localparam logic [4:0]  F_N    = 5'b10000;
    localparam logic [4:0]  F_Z    = 5'b01000;
    localparam logic [4:0]  F_C    = 5'b00100;
    localparam logic [4:0]  F_V    = 5'b00010;
    localparam logic [15:0] NOP_HW = 16'h4600;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_inst_valid;
    logic              i_stall;
    logic [15:0]       i_inst_hw;
    logic [APSR_W-1:0] i_apsr;
    logic              i_flush;
    logic              i_itstate_wr;
    logic [7:0]        i_itstate_wdata;
    logic [7:0]        o_itstate;
    logic              o_in_it_blk;
    logic [3:0]        o_cur_cond;
    logic              o_hint_or_exc;
    logic              o_it_last;
    logic              o_it_illegal;
    logic [CNT_W-1:0]  o_skip_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    it_seq_ctrl #(
        .CNT_W  (CNT_W),
        .APSR_W (APSR_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_inst_valid    (i_inst_valid),
        .i_stall         (i_stall),
        .i_inst_hw       (i_inst_hw),
        .i_apsr          (i_apsr),
        .i_flush         (i_flush),
        .i_itstate_wr    (i_itstate_wr),
        .i_itstate_wdata (i_itstate_wdata),
        .o_itstate       (o_itstate),
        .o_in_it_blk     (o_in_it_blk),
        .o_cur_cond      (o_cur_cond),
        .o_hint_or_exc   (o_hint_or_exc),
        .o_it_last       (o_it_last),
        .o_it_illegal    (o_it_illegal),
        .o_skip_cnt      (o_skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [15:0] hw, input logic [4:0] flags);
        i_inst_valid = valid;
        i_inst_hw    = hw;
        i_apsr       = flags;
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        i_inst_valid    = 1'b0;
        i_stall         = 1'b0;
        i_inst_hw       = 16'h0000;
        i_apsr          = F_NONE;
        i_flush         = 1'b0;
        i_itstate_wr    = 1'b0;
        i_itstate_wdata = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_itstate", o_itstate, 8'h00);
        check("rst_in_blk", o_in_it_blk, 1'b0);
        check("rst_cur_cond", o_cur_cond, 4'hE);
        check("rst_hint", o_hint_or_exc, 1'b0);
        check("rst_last", o_it_last, 1'b0);
        check("rst_illegal", o_it_illegal, 1'b0);
        check("rst_skip", o_skip_cnt, 3'd0);
        rst = 1'b0;

        // ITTE EQ with Z=1: T T E -> pass pass fail
        drive(1'b1, 16'hBF06, F_Z);
        check("t2_it_hint", o_hint_or_exc, 1'b0);
        tick();
        drive(1'b1, NOP_HW, F_Z);
        check("t2_its0", o_itstate, 8'h06);
        check("t2_inblk0", o_in_it_blk, 1'b1);
        check("t2_cond0", o_cur_cond, 4'h0);
        check("t2_hint0", o_hint_or_exc, 1'b0);
        check("t2_last0", o_it_last, 1'b0);
        tick();
        check("t2_its1", o_itstate, 8'h0C);
        check("t2_cond1", o_cur_cond, 4'h0);
        check("t2_hint1", o_hint_or_exc, 1'b0);
        tick();
        check("t2_its2", o_itstate, 8'h18);
        check("t2_cond2", o_cur_cond, 4'h1);
        check("t2_hint2", o_hint_or_exc, 1'b1);
        check("t2_last2", o_it_last, 1'b1);
        tick();
        check("t2_its3", o_itstate, 8'h00);
        check("t2_inblk3", o_in_it_blk, 1'b0);
        check("t2_skip", o_skip_cnt, 3'd1);

        // Same block with Z=0: fail fail pass
        drive(1'b1, 16'hBF06, F_NONE);
        tick();
        drive(1'b1, NOP_HW, F_NONE);
        check("t3_hint0", o_hint_or_exc, 1'b1);
        tick();
        check("t3_hint1", o_hint_or_exc, 1'b1);
        tick();
        check("t3_hint2", o_hint_or_exc, 1'b0);
        tick();
        check("t3_inblk", o_in_it_blk, 1'b0);
        check("t3_skip", o_skip_cnt, 3'd3);

        // Flush abandons the block
        drive(1'b1, 16'hBF06, F_Z);
        tick();
        drive(1'b1, NOP_HW, F_Z);
        check("t4_its0", o_itstate, 8'h06);
        tick();
        drive(1'b0, NOP_HW, F_Z);
        i_flush = 1'b1;
        #1;
        tick();
        i_flush = 1'b0;
        check("t4_flushed", o_itstate, 8'h00);
        drive(1'b1, NOP_HW, F_NONE);
        check("t4_hint", o_hint_or_exc, 1'b0);
        check("t4_cond", o_cur_cond, 4'hE);
        tick();
        check("t4_skip", o_skip_cnt, 3'd3);

        // Illegal IT encodings
        drive(1'b1, 16'hBFE4, F_NONE);
        tick();
        drive(1'b1, NOP_HW, F_NONE);
        check("t5_e4_its", o_itstate, 8'h00);
        check("t5_e4_ill", o_it_illegal, 1'b1);
        check("t5_e4_hint", o_hint_or_exc, 1'b0);
        tick();
        check("t5_ill_clear", o_it_illegal, 1'b0);
        drive(1'b1, 16'hBFE6, F_NONE);
        tick();
        check("t5_e6_ill", o_it_illegal, 1'b1);
        check("t5_e6_its", o_itstate, 8'h00);
        drive(1'b1, 16'hBFF8, F_NONE);
        tick();
        check("t5_f8_ill", o_it_illegal, 1'b1);
        check("t5_f8_its", o_itstate, 8'h00);
        drive(1'b1, 16'hBFE8, F_NONE);
        tick();
        drive(1'b1, NOP_HW, F_NONE);
        check("t5_al_its", o_itstate, 8'hE8);
        check("t5_al_ill", o_it_illegal, 1'b0);
        check("t5_al_cond", o_cur_cond, 4'hE);
        check("t5_al_hint", o_hint_or_exc, 1'b0);
        tick();
        check("t5_al_done", o_itstate, 8'h00);
        drive(1'b1, 16'hBF08, F_Z);
        tick();
        drive(1'b1, 16'hBF18, F_Z);
        check("t5_nest_its", o_itstate, 8'h08);
        tick();
        check("t5_nest_ill", o_it_illegal, 1'b1);
        check("t5_nest_adv", o_itstate, 8'h00);
        check("t5_nest_skip", o_skip_cnt, 3'd3);

        // Condition evaluation: GT, LS fail; HI, GE pass
        drive(1'b1, 16'hBFC8, F_N);
        tick();
        drive(1'b1, NOP_HW, F_N);
        check("gt_its", o_itstate, 8'hC8);
        check("gt_hint", o_hint_or_exc, 1'b1);
        tick();
        drive(1'b1, 16'hBF98, F_C);
        tick();
        drive(1'b1, NOP_HW, F_C);
        check("ls_cond", o_cur_cond, 4'h9);
        check("ls_hint", o_hint_or_exc, 1'b1);
        tick();
        drive(1'b1, 16'hBF88, F_C);
        tick();
        drive(1'b1, NOP_HW, F_C);
        check("hi_hint", o_hint_or_exc, 1'b0);
        tick();
        drive(1'b1, 16'hBFA8, F_N | F_V);
        tick();
        drive(1'b1, NOP_HW, F_N | F_V);
        check("ge_hint", o_hint_or_exc, 1'b0);
        tick();
        check("cond_skip", o_skip_cnt, 3'd5);

        // Stall holds state while outputs track apsr
        drive(1'b1, 16'hBF06, F_NONE);
        tick();
        i_stall = 1'b1;
        drive(1'b1, NOP_HW, F_NONE);
        check("st_hint", o_hint_or_exc, 1'b1);
        tick();
        check("st_its", o_itstate, 8'h06);
        check("st_skip", o_skip_cnt, 3'd5);
        drive(1'b1, NOP_HW, F_Z);
        check("st_hint_track", o_hint_or_exc, 1'b0);

        // ITSTATE restore wins over a simultaneous instruction
        i_stall         = 1'b0;
        i_itstate_wr    = 1'b1;
        i_itstate_wdata = 8'h5A;
        #1;
        tick();
        i_itstate_wr = 1'b0;
        check("wr_its", o_itstate, 8'h5A);
        check("wr_cond", o_cur_cond, 4'h5);
        check("wr_skip", o_skip_cnt, 3'd5);

        // Saturation of the skip counter
        drive(1'b1, NOP_HW, F_N);
        check("sat_hint0", o_hint_or_exc, 1'b1);
        tick();
        check("sat_its1", o_itstate, 8'h54);
        check("sat_skip1", o_skip_cnt, 3'd6);
        tick();
        check("sat_its2", o_itstate, 8'h48);
        check("sat_skip2", o_skip_cnt, 3'd7);
        check("sat_cond2", o_cur_cond, 4'h4);
        check("sat_hint2", o_hint_or_exc, 1'b0);
        drive(1'b1, NOP_HW, F_NONE);
        check("sat_hint3", o_hint_or_exc, 1'b1);
        tick();
        check("sat_its3", o_itstate, 8'h00);
        check("sat_skip3", o_skip_cnt, 3'd7);

        // Reset in the middle of a block
        drive(1'b1, 16'hBF06, F_NONE);
        tick();
        drive(1'b1, NOP_HW, F_NONE);
        check("mr_inblk", o_in_it_blk, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_its", o_itstate, 8'h00);
        check("mr_skip", o_skip_cnt, 3'd0);
        check("mr_hint", o_hint_or_exc, 1'b0);
        check("mr_cond", o_cur_cond, 4'hE);
        tick();
        check("mr_skip_after", o_skip_cnt, 3'd0);

        i_inst_valid = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
